rd_fifo_ctrl: RTL and testbench
===============================

# rd_fifo_ctrl

Read-side controller for the async FIFO, in the read clock domain. Consumes the write pointer after the read-domain synchronizer. Sequences synchronous reads from the FIFO memory and presents data through a first-word-fall-through valid/ready port with a 2-entry output buffer. Produces the Gray read pointer sent to the write-domain synchronizer, plus empty, almost-empty, level and underflow status.

## Interface
Parameters:
- ADDRESS_WIDTH, 4: memory address width; depth = 2**ADDRESS_WIDTH; pointers are ADDRESS_WIDTH+1 bits.
- DATA_WIDTH, 32: word width.
- AEMPTY_LVL, 2: almost_empty asserts when rd_level <= AEMPTY_LVL.

Ports:
- clk, input, 1: read-domain clock.
- sw_rst, input, 1: reset, synchronous, active-high.
- wr_ptr_gray_sync, input, ADDRESS_WIDTH+1: Gray write pointer, already synchronized into clk.
- mem_rd_en, output, 1: memory read strobe (combinational).
- rd_addr, output, ADDRESS_WIDTH: memory read address = rd_ptr_bin[ADDRESS_WIDTH-1:0].
- mem_rdata, input, DATA_WIDTH: memory data, valid 1 cycle after mem_rd_en.
- rd_data, output, DATA_WIDTH: head word of output buffer.
- rd_valid, output, 1: rd_data valid.
- rd_ready, input, 1: consumer accepts; pop = rd_valid & rd_ready.
- rd_ptr_gray, output, ADDRESS_WIDTH+1: registered Gray read pointer, to write-domain synchronizer.
- empty, output, 1: = !rd_valid.
- almost_empty, output, 1: registered, rd_level <= AEMPTY_LVL.
- rd_level, output, ADDRESS_WIDTH+1: registered count of words not yet popped.
- underflow, output, 1: registered 1-cycle pulse.

## Operation
- Internal pointers:
  - rd_ptr_bin: binary, ADDRESS_WIDTH+1 bits.
  - wr_bin: gray2bin(wr_ptr_gray_sync).
  - mem_empty = (bin2gray(rd_ptr_bin) == wr_ptr_gray_sync).
- Occupancy FSM on the output buffer (occ = words held):
  - States: OCC0, OCC1, OCC2.
  - inflight: register, set to mem_rd_en of the previous cycle.
- Fetch rule: mem_rd_en = !mem_empty && (occ + inflight - pop) < 2.
  - On fetch, rd_ptr_bin increments modulo 2**(ADDRESS_WIDTH+1).
  - rd_ptr_gray <= bin2gray(next rd_ptr_bin).
- Capture: when inflight=1, mem_rdata is written into the buffer tail.
- Buffer order: strict FIFO. The head moves to slot 0 on pop.
- FSM transitions:
  - Capture without pop: +1.
  - Pop without capture: -1.
  - Capture and pop together: unchanged.
  - OCC2 with capture and no pop cannot occur; the fetch rule guarantees this. Verification asserts it.
- Level: rd_level <= (wr_bin - rd_ptr_bin) + occ + inflight, computed modulo 2**(ADDRESS_WIDTH+1), next-state values. Maximum is depth.
- Underflow: underflow <= rd_ready && !rd_valid. Pointer and buffer are unaffected.
- Reset (sw_rst=1), effective next edge:
  - rd_ptr_bin=0, rd_ptr_gray=0, occ=0, inflight=0.
  - rd_valid=0, rd_data=0, rd_level=0, almost_empty=1, underflow=0.
  - mem_rd_en=0 while sw_rst is high.
  - Data returning from a fetch issued before reset is discarded.

## Timing
- wr_ptr_gray_sync change at edge t, FIFO previously empty:
  - mem_rd_en high in cycle t.
  - mem_rdata in cycle t+1.
  - rd_valid=1 from cycle t+2.
- Sustained throughput: 1 word/cycle with rd_ready held high and mem_empty=0.
- With rd_ready low: at most 2 words buffered. mem_rd_en stays 0 once occ + inflight = 2.
- rd_data and rd_valid are stable while rd_valid && !rd_ready.
- rd_ptr_gray updates the cycle after each fetch. Only one bit changes per update.
- Pointer wrap: rd_ptr_bin goes from 2**(ADDRESS_WIDTH+1)-1 to 0. rd_addr wraps from depth-1 to 0.

## Structure
- Package rd_fifo_pkg:
  - Functions bin2gray and gray2bin, parameterized by width.
  - occ_state_e enum {OCC0, OCC1, OCC2}.
- Sub-module rd_out_buf: the 2-entry FIFO output buffer (push from mem_rdata, pop from rd_ready, occ output).
- Top level: pointers, fetch rule, status.

## Test plan
- Reset: hold sw_rst 2 cycles -> rd_valid=0, rd_ptr_gray=5'b00000, rd_level=0, almost_empty=1, mem_rd_en=0.
- Single word: wr_ptr_gray_sync 0 -> 5'b00001 at t -> mem_rd_en=1 and rd_addr=0 at t; rd_valid=1 at t+2 with memory word 0; pop -> rd_ptr_gray=5'b00001, empty=1.
- Stream and wrap, rd_ready=1:
  - Write pointer advanced to 16, then 20.
  - Expect 20 consecutive rd_valid cycles with data in order.
  - rd_addr goes 15 -> 0.
  - rd_ptr_bin ends at 20, so rd_ptr_gray=5'b11110.
- Backpressure: 5 words available, rd_ready=0 -> exactly 2 mem_rd_en pulses, rd_level=5, rd_data constant. Then rd_ready=1 -> 5 words in order, no gaps after the first.
- Underflow: rd_ready=1 with FIFO empty for 3 cycles -> underflow pulses each cycle, rd_ptr_gray unchanged.
- Reset mid-stream: sw_rst in the cycle after mem_rd_en -> next cycle rd_valid=0, rd_ptr_gray=0; the returning mem_rdata never appears on rd_data.

Source files
------------

// File: rtl/rd_fifo_pkg.sv
// Shared types and pointer-code helpers for the async FIFO read-side controller.
package rd_fifo_pkg;

   // Helpers operate on a zero-extended word so any pointer width up to this fits.
   localparam int GRAY_MAX_W = 32;

   typedef enum logic [1:0] {
      OCC0 = 2'd0,
      OCC1 = 2'd1,
      OCC2 = 2'd2
   } occ_state_e;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Prefix XOR from the MSB down; zero padding above the real width is harmless.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
      logic [GRAY_MAX_W-1:0] bin;
      bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/rd_fifo_ctrl_rd_out_buf.sv
// Two-entry first-word-fall-through output buffer; slot 0 is always the head word.
module rd_out_buf
   import rd_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  sw_rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [1:0]            occ,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid
);

   occ_state_e            occ_r;
   occ_state_e            occ_next_s;
   logic                  rd_valid_r;
   logic [DATA_WIDTH-1:0] slot0_r;
   logic [DATA_WIDTH-1:0] slot1_r;
   logic                  head_wr_s;
   logic                  tail_wr_s;
   logic                  shift_s;

   // Occupancy state register and registered valid flag.
   always_ff @(posedge clk) begin
      if (sw_rst) begin
         occ_r      <= OCC0;
         rd_valid_r <= 1'b0;
      end else begin
         occ_r      <= occ_next_s;
         rd_valid_r <= (occ_next_s != OCC0);
      end
   end

   // Next occupancy: push adds a word, pop removes one, both together hold.
   always_comb begin
      occ_next_s = occ_r;
      case (occ_r)
         OCC0: begin
            if (push) begin
               occ_next_s = OCC1;
            end else begin
               occ_next_s = OCC0;
            end
         end
         OCC1: begin
            if (push && !pop) begin
               occ_next_s = OCC2;
            end else if (!push && pop) begin
               occ_next_s = OCC0;
            end else begin
               occ_next_s = OCC1;
            end
         end
         OCC2: begin
            if (pop && !push) begin
               occ_next_s = OCC1;
            end else begin
               occ_next_s = OCC2;
            end
         end
         default: begin
            occ_next_s = OCC0;
         end
      endcase
   end

   // Slot steering: a word lands at the head only when it becomes the head next cycle.
   always_comb begin
      head_wr_s = 1'b0;
      tail_wr_s = 1'b0;
      shift_s   = 1'b0;
      case (occ_r)
         OCC0: begin
            head_wr_s = push;
         end
         OCC1: begin
            if (push && pop) begin
               head_wr_s = 1'b1;
            end else if (push) begin
               tail_wr_s = 1'b1;
            end else begin
               head_wr_s = 1'b0;
            end
         end
         OCC2: begin
            shift_s   = pop;
            tail_wr_s = push && pop;
         end
         default: begin
            head_wr_s = 1'b0;
         end
      endcase
   end

   // Data slots; reset clears them so stale words never reach the consumer.
   always_ff @(posedge clk) begin
      if (sw_rst) begin
         slot0_r <= {DATA_WIDTH{1'b0}};
         slot1_r <= {DATA_WIDTH{1'b0}};
      end else begin
         if (head_wr_s) begin
            slot0_r <= push_data;
         end else if (shift_s) begin
            slot0_r <= slot1_r;
         end else begin
            slot0_r <= slot0_r;
         end
         if (tail_wr_s) begin
            slot1_r <= push_data;
         end else begin
            slot1_r <= slot1_r;
         end
      end
   end

   assign occ      = occ_r;
   assign rd_data  = slot0_r;
   assign rd_valid = rd_valid_r;

endmodule

// File: rtl/rd_fifo_ctrl.sv
// Read-side controller of the async FIFO: pointers, fetch rule, FWFT output and status.
module rd_fifo_ctrl
   import rd_fifo_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 4,
   parameter int DATA_WIDTH    = 32,
   parameter int AEMPTY_LVL    = 2
) (
   input  logic                   clk,
   input  logic                   sw_rst,
   input  logic [ADDRESS_WIDTH:0] wr_ptr_gray_sync,
   output logic                   mem_rd_en,
   output logic [ADDRESS_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0]  mem_rdata,
   output logic [DATA_WIDTH-1:0]  rd_data,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [ADDRESS_WIDTH:0] rd_ptr_gray,
   output logic                   empty,
   output logic                   almost_empty,
   output logic [ADDRESS_WIDTH:0] rd_level,
   output logic                   underflow
);

   localparam int PTR_W = ADDRESS_WIDTH + 1;
   localparam logic [PTR_W-1:0] AEMPTY_THR = PTR_W'(AEMPTY_LVL);

   logic [PTR_W-1:0] rd_ptr_bin_r;
   logic [PTR_W-1:0] rd_ptr_bin_next_s;
   logic [PTR_W-1:0] rd_ptr_gray_r;
   logic [PTR_W-1:0] wr_bin_s;
   logic [PTR_W-1:0] level_next_s;
   logic [PTR_W-1:0] rd_level_r;
   logic             mem_empty_s;
   logic             inflight_r;
   logic             pop_s;
   logic             fetch_s;
   logic [1:0]       occ_s;
   logic [2:0]       pending_s;
   logic             almost_empty_r;
   logic             underflow_r;

   rd_out_buf #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_out_buf (
      .clk      (clk),
      .sw_rst   (sw_rst),
      .push     (inflight_r),
      .push_data(mem_rdata),
      .pop      (pop_s),
      .occ      (occ_s),
      .rd_data  (rd_data),
      .rd_valid (rd_valid)
   );

   assign pop_s       = rd_valid && rd_ready;
   assign wr_bin_s    = PTR_W'(gray2bin(GRAY_MAX_W'(wr_ptr_gray_sync)));
   assign mem_empty_s = (PTR_W'(bin2gray(GRAY_MAX_W'(rd_ptr_bin_r))) == wr_ptr_gray_sync);

   // Words buffered plus in flight once this cycle's pop retires; also next-cycle occupancy.
   assign pending_s = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_s};

   // Fetch only while the memory holds unread words and the buffer can absorb the return.
   always_comb begin
      fetch_s = 1'b0;
      if (sw_rst) begin
         fetch_s = 1'b0;
      end else if (mem_empty_s) begin
         fetch_s = 1'b0;
      end else begin
         fetch_s = (pending_s < 3'd2);
      end
   end

   // Next pointer and the unpopped-word count it implies.
   always_comb begin
      rd_ptr_bin_next_s = rd_ptr_bin_r + PTR_W'(fetch_s);
      level_next_s      = (wr_bin_s - rd_ptr_bin_next_s) + PTR_W'(pending_s) + PTR_W'(fetch_s);
   end

   // Pointer, in-flight tracking and status registers.
   always_ff @(posedge clk) begin
      if (sw_rst) begin
         rd_ptr_bin_r   <= {PTR_W{1'b0}};
         rd_ptr_gray_r  <= {PTR_W{1'b0}};
         inflight_r     <= 1'b0;
         rd_level_r     <= {PTR_W{1'b0}};
         almost_empty_r <= 1'b1;
         underflow_r    <= 1'b0;
      end else begin
         rd_ptr_bin_r   <= rd_ptr_bin_next_s;
         rd_ptr_gray_r  <= PTR_W'(bin2gray(GRAY_MAX_W'(rd_ptr_bin_next_s)));
         inflight_r     <= fetch_s;
         rd_level_r     <= level_next_s;
         almost_empty_r <= (level_next_s <= AEMPTY_THR);
         underflow_r    <= rd_ready && !rd_valid;
      end
   end

   assign mem_rd_en    = fetch_s;
   assign rd_addr      = rd_ptr_bin_r[ADDRESS_WIDTH-1:0];
   assign rd_ptr_gray  = rd_ptr_gray_r;
   assign empty        = !rd_valid;
   assign almost_empty = almost_empty_r;
   assign rd_level     = rd_level_r;
   assign underflow    = underflow_r;

endmodule

// File: tb/tb_rd_fifo_ctrl.sv
// Directed self-checking bench for rd_fifo_ctrl with a synchronous memory model.
module tb_rd_fifo_ctrl;

   logic        clk;
   logic        sw_rst;
   logic [4:0]  wr_ptr_gray_sync;
   logic        mem_rd_en;
   logic [3:0]  rd_addr;
   logic [31:0] mem_rdata;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic [4:0]  rd_ptr_gray;
   logic        empty;
   logic        almost_empty;
   logic [4:0]  rd_level;
   logic        underflow;

   logic [31:0] mem [16];
   int          wr_cnt;
   int          errors;
   int          checks;

   rd_fifo_ctrl #(
      .ADDRESS_WIDTH(4),
      .DATA_WIDTH   (32),
      .AEMPTY_LVL   (2)
   ) dut (
      .clk             (clk),
      .sw_rst          (sw_rst),
      .wr_ptr_gray_sync(wr_ptr_gray_sync),
      .mem_rd_en       (mem_rd_en),
      .rd_addr         (rd_addr),
      .mem_rdata       (mem_rdata),
      .rd_data         (rd_data),
      .rd_valid        (rd_valid),
      .rd_ready        (rd_ready),
      .rd_ptr_gray     (rd_ptr_gray),
      .empty           (empty),
      .almost_empty    (almost_empty),
      .rd_level        (rd_level),
      .underflow       (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem[rd_addr];
   end

   function automatic logic [31:0] data_of(input int w);
      return 32'hC0DE_0000 + 32'(w);
   endfunction

   function automatic logic [4:0] to_gray(input int b);
      logic [4:0] v;
      v = 5'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_words(input int n);
      for (int k = 0; k < n; k++) begin
         mem[wr_cnt % 16] = data_of(wr_cnt);
         wr_cnt = wr_cnt + 1;
      end
      wr_ptr_gray_sync = to_gray(wr_cnt);
      #1;
   endtask

   task automatic do_reset();
      sw_rst = 1'b1;
      rd_ready = 1'b0;
      wr_cnt = 0;
      wr_ptr_gray_sync = 5'b00000;
      step();
      step();
      sw_rst = 1'b0;
   endtask

   task automatic test_reset();
      sw_rst = 1'b1;
      rd_ready = 1'b0;
      wr_cnt = 0;
      wr_ptr_gray_sync = 5'b00011;
      step();
      step();
      checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_mem_rd_en: got %b want 0", mem_rd_en); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
      checks++; if (rd_ptr_gray !== 5'b00000) begin errors++; $display("FAIL reset_rd_ptr_gray: got %b want 00000", rd_ptr_gray); end
      checks++; if (rd_level !== 5'd0) begin errors++; $display("FAIL reset_rd_level: got %0d want 0", rd_level); end
      checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b want 1", almost_empty); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b want 0", underflow); end
      checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
      wr_ptr_gray_sync = 5'b00000;
      sw_rst = 1'b0;
      step();
   endtask

   task automatic test_single_word();
      do_reset();
      push_words(1);
      checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("FAIL single_fetch: got %b want 1", mem_rd_en); end
      checks++; if (rd_addr !== 4'd0) begin errors++; $display("FAIL single_addr: got %0d want 0", rd_addr); end
      step();
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_valid_t1: got %b want 0", rd_valid); end
      checks++; if (rd_ptr_gray !== 5'b00001) begin errors++; $display("FAIL single_gray_t1: got %b want 00001", rd_ptr_gray); end
      checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL single_no_refetch: got %b want 0", mem_rd_en); end
      step();
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL single_valid_t2: got %b want 1", rd_valid); end
      checks++; if (rd_data !== data_of(0)) begin errors++; $display("FAIL single_data: got %h want %h", rd_data, data_of(0)); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_t2: got %b want 0", empty); end
      checks++; if (rd_level !== 5'd1) begin errors++; $display("FAIL single_level: got %0d want 1", rd_level); end
      checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL single_aempty: got %b want 1", almost_empty); end
      rd_ready = 1'b1;
      step();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_pop: got %b want 1", empty); end
      checks++; if (rd_ptr_gray !== 5'b00001) begin errors++; $display("FAIL single_gray_pop: got %b want 00001", rd_ptr_gray); end
      checks++; if (rd_level !== 5'd0) begin errors++; $display("FAIL single_level_pop: got %0d want 0", rd_level); end
      rd_ready = 1'b0;
   endtask

   task automatic test_stream_wrap();
      int exp_idx;
      int gaps;
      int prev_addr;
      bit wrapped;
      do_reset();
      rd_ready = 1'b1;
      push_words(16);
      exp_idx = 0; gaps = 0; prev_addr = -1; wrapped = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (mem_rd_en) begin
            if (prev_addr == 15 && rd_addr == 4'd0) wrapped = 1'b1;
            prev_addr = int'(rd_addr);
         end
         if (rd_valid) begin
            checks++;
            if (rd_data !== data_of(exp_idx)) begin
               errors++; $display("FAIL stream_data[%0d]: got %h want %h", exp_idx, rd_data, data_of(exp_idx));
            end
            exp_idx++;
         end else if (exp_idx > 0 && exp_idx < 20) begin
            gaps++;
         end
         step();
         if (i == 8) push_words(4);
      end
      checks++; if (exp_idx !== 20) begin errors++; $display("FAIL stream_count: got %0d want 20", exp_idx); end
      checks++; if (gaps !== 0) begin errors++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
      checks++; if (wrapped !== 1'b1) begin errors++; $display("FAIL stream_addr_wrap: got %b want 1", wrapped); end
      checks++; if (rd_ptr_gray !== 5'b11110) begin errors++; $display("FAIL stream_gray: got %b want 11110", rd_ptr_gray); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty: got %b want 1", empty); end
      rd_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int pulses;
      int got;
      int gaps;
      do_reset();
      rd_ready = 1'b0;
      push_words(5);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         if (mem_rd_en) pulses++;
         if (rd_valid) begin
            checks++;
            if (rd_data !== data_of(0)) begin errors++; $display("FAIL bp_hold_data: got %h want %h", rd_data, data_of(0)); end
         end
         step();
      end
      checks++; if (pulses !== 2) begin errors++; $display("FAIL bp_fetch_pulses: got %0d want 2", pulses); end
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", rd_valid); end
      checks++; if (rd_level !== 5'd5) begin errors++; $display("FAIL bp_level: got %0d want 5", rd_level); end
      checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL bp_aempty: got %b want 0", almost_empty); end
      rd_ready = 1'b1;
      got = 0; gaps = 0;
      for (int i = 0; i < 12; i++) begin
         if (rd_valid) begin
            checks++;
            if (rd_data !== data_of(got)) begin errors++; $display("FAIL bp_drain[%0d]: got %h want %h", got, rd_data, data_of(got)); end
            got++;
         end else if (got > 0 && got < 5) begin
            gaps++;
         end
         step();
      end
      checks++; if (got !== 5) begin errors++; $display("FAIL bp_drain_count: got %0d want 5", got); end
      checks++; if (gaps !== 0) begin errors++; $display("FAIL bp_drain_gaps: got %0d want 0", gaps); end
      checks++; if (rd_ptr_gray !== 5'b00111) begin errors++; $display("FAIL bp_gray: got %b want 00111", rd_ptr_gray); end
      rd_ready = 1'b0;
   endtask

   task automatic test_underflow();
      do_reset();
      rd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_pulse[%0d]: got %b want 1", i, underflow); end
         checks++; if (rd_ptr_gray !== 5'b00000) begin errors++; $display("FAIL underflow_gray[%0d]: got %b want 00000", i, rd_ptr_gray); end
         checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL underflow_fetch[%0d]: got %b want 0", i, mem_rd_en); end
      end
      rd_ready = 1'b0;
      step();
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %b want 0", underflow); end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      push_words(1);
      checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("FAIL mid_fetch: got %b want 1", mem_rd_en); end
      step();
      sw_rst = 1'b1;
      wr_cnt = 0;
      wr_ptr_gray_sync = 5'b00000;
      step();
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", rd_valid); end
      checks++; if (rd_ptr_gray !== 5'b00000) begin errors++; $display("FAIL mid_gray: got %b want 00000", rd_ptr_gray); end
      sw_rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_after_valid[%0d]: got %b want 0", i, rd_valid); end
         checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL mid_after_data[%0d]: got %h want 0", i, rd_data); end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      wr_cnt = 0;
      sw_rst = 1'b1;
      rd_ready = 1'b0;
      wr_ptr_gray_sync = 5'b00000;
      mem_rdata = 32'h0;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      test_reset();
      test_single_word();
      test_stream_wrap();
      test_backpressure();
      test_underflow();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
